// File: rtl/smallarray_arbiter.sv
// Round-robin two-requester arbiter/sequencer for the banked 16x8 memory.
// Optional saturating grant counters are enabled by defining SMALLARRAY_ARB_GNT_CNT_EN.
module smallarray_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
`ifdef SMALLARRAY_ARB_GNT_CNT_EN
    output logic [CW-1:0] gnt_cnt0,
    output logic [CW-1:0] gnt_cnt1,
`endif
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wen,
    output logic          mem_ren,
    input  logic [DW-1:0] mem_odata
);

    if (AW < 1 || DW < 1 || CW < 1) begin : g_bad_param
        $error("smallarray_arbiter: AW, DW and CW must all be at least 1");
    end

    logic          r_rr_last;
    logic          r_rd_pend;
    logic          r_rd_tag;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_gnt_any;
    logic          w_gnt_we;
    logic [AW-1:0] w_gnt_addr;
    logic [DW-1:0] w_gnt_wdata;

    // Grant decision; held at zero while reset is asserted.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else begin
            case ({req1_valid, req0_valid})
                2'b01: w_gnt0 = 1'b1;
                2'b10: w_gnt1 = 1'b1;
                2'b11: begin
                    // Contention: the requester not served last time wins.
                    if (r_rr_last) begin
                        w_gnt0 = 1'b1;
                    end else begin
                        w_gnt1 = 1'b1;
                    end
                end
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign w_gnt_any  = w_gnt0 | w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Select the granted command fields.
    always_comb begin
        w_gnt_we    = 1'b0;
        w_gnt_addr  = {AW{1'b0}};
        w_gnt_wdata = {DW{1'b0}};
        if (w_gnt0) begin
            w_gnt_we    = req0_we;
            w_gnt_addr  = req0_addr;
            w_gnt_wdata = req0_wdata;
        end else if (w_gnt1) begin
            w_gnt_we    = req1_we;
            w_gnt_addr  = req1_addr;
            w_gnt_wdata = req1_wdata;
        end else begin
            w_gnt_we    = 1'b0;
            w_gnt_addr  = {AW{1'b0}};
            w_gnt_wdata = {DW{1'b0}};
        end
    end

    // Drive the single memory port; idle cycles present an all-zero command.
    always_comb begin
        mem_addr = {AW{1'b0}};
        mem_data = {DW{1'b0}};
        mem_wen  = 1'b0;
        mem_ren  = 1'b0;
        if (w_gnt_any) begin
            mem_addr = w_gnt_addr;
            mem_data = w_gnt_wdata;
            mem_wen  = w_gnt_we;
            mem_ren  = ~w_gnt_we;
        end else begin
            mem_addr = {AW{1'b0}};
            mem_data = {DW{1'b0}};
            mem_wen  = 1'b0;
            mem_ren  = 1'b0;
        end
    end

    // Round-robin pointer and read-response tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
            r_rd_pend <= 1'b0;
            r_rd_tag  <= 1'b0;
        end else begin
            if (w_gnt_any) begin
                r_rr_last <= w_gnt1;
            end else begin
                r_rr_last <= r_rr_last;
            end
            r_rd_pend <= w_gnt_any & ~w_gnt_we;
            if (w_gnt_any && !w_gnt_we) begin
                r_rd_tag <= w_gnt1;
            end else begin
                r_rd_tag <= r_rd_tag;
            end
        end
    end

    // Steer the memory read data to the requester that issued the read.
    always_comb begin
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = {DW{1'b0}};
        rsp1_rdata = {DW{1'b0}};
        if (r_rd_pend) begin
            if (r_rd_tag) begin
                rsp1_valid = 1'b1;
                rsp1_rdata = mem_odata;
            end else begin
                rsp0_valid = 1'b1;
                rsp0_rdata = mem_odata;
            end
        end else begin
            rsp0_valid = 1'b0;
            rsp1_valid = 1'b0;
        end
    end

`ifdef SMALLARRAY_ARB_GNT_CNT_EN
    logic [CW-1:0] r_gnt_cnt0;
    logic [CW-1:0] r_gnt_cnt1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Saturating per-requester transfer counters (a grant is always a transfer).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_cnt0 <= {CW{1'b0}};
            r_gnt_cnt1 <= {CW{1'b0}};
        end else begin
            if (w_gnt0) begin
                r_gnt_cnt0 <= sat_inc(r_gnt_cnt0);
            end else begin
                r_gnt_cnt0 <= r_gnt_cnt0;
            end
            if (w_gnt1) begin
                r_gnt_cnt1 <= sat_inc(r_gnt_cnt1);
            end else begin
                r_gnt_cnt1 <= r_gnt_cnt1;
            end
        end
    end

    assign gnt_cnt0 = r_gnt_cnt0;
    assign gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule

// File: tb/tb_smallarray_arbiter.sv
// Bench for smallarray_arbiter: behavioural memory, reference model, directed and random traffic.
`timescale 1ns/1ps
module tb_smallarray_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;
`ifdef SMALLARRAY_ARB_GNT_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wen, mem_ren;
    logic [DW-1:0] mem_odata = '0;
`ifdef SMALLARRAY_ARB_GNT_CNT_EN
    logic [CW-1:0] gnt_cnt0, gnt_cnt1;
`endif

    int total = 0;
    int bad = 0;

    smallarray_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
`ifdef SMALLARRAY_ARB_GNT_CNT_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wen(mem_wen),
        .mem_ren(mem_ren), .mem_odata(mem_odata)
    );

    always #5 clk = ~clk;

    // Environment memory: write lands at the edge, read data registered one cycle.
    logic [DW-1:0] bmem [16];
    always @(posedge clk) begin
        if (mem_wen) bmem[mem_addr] <= mem_data;
        if (mem_ren) mem_odata <= bmem[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: what the arbiter must have remembered.
    logic [DW-1:0] m_mem [16];
    int            m_last = 1;
    logic          m_pend = 1'b0;
    int            m_tag = 0;
    logic [DW-1:0] m_data = '0;
    int            m_cnt0 = 0, m_cnt1 = 0;
    logic          n_go = 1'b0;
    int            n_gi = -1;
    logic          n_we = 1'b0;
    logic [AW-1:0] n_addr = '0;
    logic [DW-1:0] n_wdata = '0;

    // Every negative edge: derive the required outputs from the model and compare.
    always @(negedge clk) begin
        int            gi;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [63:0]   outs;
        outs = {req0_ready, req1_ready, mem_wen, mem_ren, mem_addr, mem_data,
                rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata};
        if (rst) begin
            chk("reset_outputs", outs, 64'd0);
`ifdef SMALLARRAY_ARB_GNT_CNT_EN
            chk("reset_counters", {gnt_cnt0, gnt_cnt1}, 64'd0);
`endif
            n_go <= 1'b0;
        end else begin
            if (req0_valid && req1_valid) gi = 1 - m_last;
            else if (req0_valid)          gi = 0;
            else if (req1_valid)          gi = 1;
            else                          gi = -1;
            we = 1'b0; a = '0; d = '0;
            if (gi == 0) begin we = req0_we; a = req0_addr; d = req0_wdata; end
            if (gi == 1) begin we = req1_we; a = req1_addr; d = req1_wdata; end
            chk("ready0", req0_ready, gi == 0);
            chk("ready1", req1_ready, gi == 1);
            chk("mem_wen", mem_wen, gi >= 0 && we);
            chk("mem_ren", mem_ren, gi >= 0 && !we);
            chk("mem_addr", mem_addr, a);
            chk("mem_data", mem_data, d);
            chk("rsp0_valid", rsp0_valid, m_pend && m_tag == 0);
            chk("rsp1_valid", rsp1_valid, m_pend && m_tag == 1);
            chk("rsp0_rdata", rsp0_rdata, (m_pend && m_tag == 0) ? m_data : 8'h00);
            chk("rsp1_rdata", rsp1_rdata, (m_pend && m_tag == 1) ? m_data : 8'h00);
`ifdef SMALLARRAY_ARB_GNT_CNT_EN
            chk("gnt_cnt0", gnt_cnt0, m_cnt0);
            chk("gnt_cnt1", gnt_cnt1, m_cnt1);
`endif
            n_go <= 1'b1; n_gi <= gi; n_we <= we; n_addr <= a; n_wdata <= d;
        end
    end

    // Model state advance at the clock edge; reset is asynchronous like the design.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last <= 1; m_pend <= 1'b0; m_cnt0 <= 0; m_cnt1 <= 0;
        end else if (n_go) begin
            m_pend <= (n_gi >= 0) && !n_we;
            m_tag  <= n_gi;
            m_data <= m_mem[n_addr];
            if (n_gi >= 0) m_last <= n_gi;
            if (n_gi >= 0 && n_we) m_mem[n_addr] <= n_wdata;
            if (n_gi == 0) m_cnt0 <= (m_cnt0 + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt0 + 1;
            if (n_gi == 1) m_cnt1 <= (m_cnt1 + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt1 + 1;
        end
    end

    task automatic drv(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(posedge clk); #1;
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    endtask

    initial begin
        logic acc0, acc1;
        for (int i = 0; i < 16; i++) begin
            bmem[i]  = 8'(i * 8'h11);
            m_mem[i] = 8'(i * 8'h11);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: memory port never strobed.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_strobes", {mem_wen, mem_ren}, 64'd0);
        end

        // Write then read back through requester 0.
        drv(1'b1, 1'b1, 4'h3, 8'hA5, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk); chk("wr_ready0", req0_ready, 64'd1);
        drv(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk); chk("rd_ready0", req0_ready, 64'd1);
        drv(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        chk("rd_rsp0", {rsp0_valid, rsp0_rdata, rsp1_valid}, {1'b1, 8'hA5, 1'b0});

        // Make requester 1 the last served, then contend for four cycles.
        drv(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'hA, 8'h5A);
        @(negedge clk); chk("wr_ready1", req1_ready, 64'd1);
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h9, 8'h00);
            @(negedge clk);
            chk("cont_grant", {req0_ready, req1_ready}, (i % 2 == 0) ? 64'd2 : 64'd1);
            if (i == 1) chk("held_addr", mem_addr, 64'h9);
            if (i == 0)          chk("cont_rsp", {rsp0_valid, rsp1_valid}, 64'd0);
            else if (i % 2 == 1) chk("cont_rsp", {rsp0_valid, rsp0_rdata, rsp1_valid}, {1'b1, 8'h11, 1'b0});
            else                 chk("cont_rsp", {rsp1_valid, rsp1_rdata, rsp0_valid}, {1'b1, 8'h99, 1'b0});
        end
        drv(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        chk("cont_rsp_last", {rsp1_valid, rsp1_rdata, rsp0_valid}, {1'b1, 8'h99, 1'b0});

        // Reset right after a granted req1 read drops the response.
        drv(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h9, 8'h00);
        @(negedge clk); chk("rst_rd_ready1", req1_ready, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1; req1_valid = 1'b0;
        @(negedge clk); chk("rst_no_rsp1", rsp1_valid, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); chk("post_rst_no_rsp1", rsp1_valid, 64'd0);
        drv(1'b1, 1'b0, 4'h2, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00);
        @(negedge clk); chk("post_rst_first", {req0_ready, req1_ready}, 64'd2);

        // Random traffic honouring the hold-until-ready rule.
        acc0 = req0_ready; acc1 = req1_ready;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 99) < 60);
                req0_we = 1'($urandom); req0_addr = 4'($urandom); req0_wdata = 8'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 99) < 60);
                req1_we = 1'($urandom); req1_addr = 4'($urandom); req1_wdata = 8'($urandom);
            end
            @(negedge clk);
            acc0 = req0_ready; acc1 = req1_ready;
        end

`ifdef SMALLARRAY_ARB_GNT_CNT_EN
        // Counter saturation after 20 requester-0 grants.
        drv(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) drv(1'b1, 1'b1, 4'(i), 8'(i), 1'b0, 1'b0, 4'h0, 8'h00);
        drv(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        chk("cnt_saturated", {gnt_cnt0, gnt_cnt1}, {4'hF, 4'h0});
`endif

        drv(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
